// File: rtl/voq_sched_if.sv
// Scheduler bundle between the VOQ buffers, the output queues and the crossbar.
// The master drives queue status; the slave (scheduler) drives read, write and mux controls.
interface voq_sched_if #(
    parameter int unsigned PORT_NUB = 4
);
    localparam int unsigned WIDTH_SEL = $clog2(PORT_NUB);

    logic                          sched_en;
    logic [PORT_NUB*PORT_NUB-1:0]  voq_empty;
    logic [PORT_NUB-1:0]           out_full;
    logic [PORT_NUB-1:0]           rd_en;
    logic [PORT_NUB*WIDTH_SEL-1:0] rd_sel;
    logic [PORT_NUB-1:0]           wr_en;
    logic [PORT_NUB*WIDTH_SEL-1:0] mux_sel;

    modport master (
        output sched_en, voq_empty, out_full,
        input  rd_en, rd_sel, wr_en, mux_sel
    );

    modport slave (
        input  sched_en, voq_empty, out_full,
        output rd_en, rd_sel, wr_en, mux_sel
    );
endinterface

// File: rtl/voq_sched.sv
// Single-iteration round-robin grant/accept matcher for an N-port VOQ switch.
// Reads issue one edge after the match; crossbar writes follow one edge later.
module voq_sched #(
    parameter int unsigned PORT_NUB = 4
) (
    input logic        clk,
    input logic        rst_n,
    voq_sched_if.slave bus
);
    localparam int unsigned N         = PORT_NUB;
    localparam int unsigned WIDTH_SEL = $clog2(PORT_NUB);

    logic [N-1:0][WIDTH_SEL-1:0] g_ptr_q, g_ptr_d;
    logic [N-1:0][WIDTH_SEL-1:0] a_ptr_q, a_ptr_d;
    logic [N-1:0]                rd_en_q, rd_en_d;
    logic [N-1:0][WIDTH_SEL-1:0] rd_sel_q, rd_sel_d;
    logic [N-1:0]                wr_en_q, wr_en_d;
    logic [N-1:0][WIDTH_SEL-1:0] mux_sel_q, mux_sel_d;

    logic [N-1:0][N-1:0]         req;    // [input][output]
    logic [N-1:0][N-1:0]         gnt;    // [output][input]
    logic [N-1:0][N-1:0]         acc;    // [input][output]
    logic                        g_found, a_found;
    logic [WIDTH_SEL-1:0]        g_idx, a_idx;

    // A VOQ read in the previous cycle still shows its stale empty flag, so mask it.
    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                req[i][j] = !bus.voq_empty[i*N+j] && !bus.out_full[j] && bus.sched_en &&
                            !(rd_en_q[i] && (rd_sel_q[i] == WIDTH_SEL'(j)));
            end
        end
    end

    always_comb begin
        gnt     = '0;
        g_found = 1'b0;
        g_idx   = '0;
        for (int j = 0; j < N; j++) begin
            g_found = 1'b0;
            for (int k = 0; k < N; k++) begin
                g_idx = g_ptr_q[j] + WIDTH_SEL'(k);
                if (!g_found && req[g_idx][j]) begin
                    gnt[j][g_idx] = 1'b1;
                    g_found       = 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc     = '0;
        a_found = 1'b0;
        a_idx   = '0;
        for (int i = 0; i < N; i++) begin
            a_found = 1'b0;
            for (int k = 0; k < N; k++) begin
                a_idx = a_ptr_q[i] + WIDTH_SEL'(k);
                if (!a_found && gnt[a_idx][i]) begin
                    acc[i][a_idx] = 1'b1;
                    a_found       = 1'b1;
                end
            end
        end
    end

    always_comb begin
        g_ptr_d   = g_ptr_q;
        a_ptr_d   = a_ptr_q;
        rd_en_d   = '0;
        rd_sel_d  = rd_sel_q;
        wr_en_d   = '0;
        mux_sel_d = mux_sel_q;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (acc[i][j]) begin
                    rd_en_d[i]  = 1'b1;
                    rd_sel_d[i] = WIDTH_SEL'(j);
                    a_ptr_d[i]  = WIDTH_SEL'(j + 1);
                    g_ptr_d[j]  = WIDTH_SEL'(i + 1);
                end
            end
        end
        // The write stage is derived from last cycle's reads, independent of sched_en.
        for (int i = 0; i < N; i++) begin
            if (rd_en_q[i]) begin
                wr_en_d[rd_sel_q[i]]   = 1'b1;
                mux_sel_d[rd_sel_q[i]] = WIDTH_SEL'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_ptr_q   <= '0;
            a_ptr_q   <= '0;
            rd_en_q   <= '0;
            rd_sel_q  <= '0;
            wr_en_q   <= '0;
            mux_sel_q <= '0;
        end else begin
            g_ptr_q   <= g_ptr_d;
            a_ptr_q   <= a_ptr_d;
            rd_en_q   <= rd_en_d;
            rd_sel_q  <= rd_sel_d;
            wr_en_q   <= wr_en_d;
            mux_sel_q <= mux_sel_d;
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_sel  = rd_sel_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.mux_sel = mux_sel_q;
endmodule

// File: doc/voq_sched.md
VOQ_SCHED -- requirements
Module: voq_sched

Interface
REQ-001 SHALL have parameter PORT_NUB, default 4: number of switch ports N; the design SHALL support N = 2..16, powers of two.
REQ-002 SHALL derive localparam WIDTH_SEL = $clog2(PORT_NUB): width of one select field W.
REQ-003 SHALL have clk  input  1: clock; all state SHALL update on the rising edge.
REQ-004 SHALL have rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have sched_en  input  1: while high, new matches are permitted.
REQ-006 SHALL have voq_empty  input  N*N: bit [i*N+j] high = the VOQ at input i holding cells for output j is empty.
REQ-007 SHALL have out_full  input  N: bit j high = output queue j cannot accept new matches.
REQ-008 SHALL have rd_en  output  N: bit i = pop one cell from input i.
REQ-009 SHALL have rd_sel  output  N*W: field i = VOQ (output index) that input i pops.
REQ-010 SHALL have wr_en  output  N: bit j = write one cell into output j.
REQ-011 SHALL have mux_sel  output  N*W: field j = input index routed to output j.

Function
REQ-012 Request r[i][j] SHALL equal !voq_empty[i*N+j] & !out_full[j] & sched_en & !inflight[i][j].
REQ-013 inflight[i][j] SHALL be high in the cycle where rd_en[i]=1 and rd_sel field i = j; this masks the stale empty flag.
REQ-014 Grant: each output j SHALL grant the first requesting input found searching cyclically from g_ptr[j] (g_ptr[j], g_ptr[j]+1, ..., wrapping N-1 to 0).
REQ-015 Accept: each input i SHALL accept the first granting output found searching cyclically from a_ptr[i].
REQ-016 The result SHALL be a single-iteration match: at most one accept per input and at most one grant accepted per output.
REQ-017 For a match (i,j) computed from inputs in cycle t, rd_en[i]=1 and rd_sel field i = j SHALL be registered at edge t+1.
REQ-018 For the same match, wr_en[j]=1 and mux_sel field j = i SHALL be registered at edge t+2, aligning with the one-cycle buffer read latency.
REQ-019 On an accepted match (i,j) at edge t+1, the block SHALL set g_ptr[j] <= (i+1) mod N and a_ptr[i] <= (j+1) mod N.
REQ-020 Pointers SHALL NOT change for a grant that is not accepted.
REQ-021 Outputs and inputs with no match SHALL hold their pointers.
REQ-022 rd_sel fields SHALL hold their last value while the corresponding rd_en is 0; mux_sel fields SHALL hold their last value while the corresponding wr_en is 0.
REQ-023 sched_en falling SHALL stop new rd_en from the next edge; wr_en for matches already read SHALL still issue.
REQ-024 out_full SHALL be treated as almost-full by its driver: after out_full[j] rises, at most 2 further wr_en[j] pulses SHALL occur.
REQ-025 When all requests are zero, rd_en and wr_en SHALL be all zero and no pointer SHALL move.
REQ-026 Sustained throughput SHALL be one cell per cycle per output, provided distinct VOQs are eligible.
REQ-027 A single VOQ SHALL be served at most every other cycle because of the REQ-013 mask.

Reset
REQ-028 When rst_n is low, all g_ptr, a_ptr, pipeline registers, rd_en, rd_sel, wr_en and mux_sel SHALL be 0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard in-flight matches; no wr_en SHALL issue after rst_n deasserts for matches made before reset.
REQ-030 The first match SHALL be possible from the first rising edge after rst_n deasserts.

Verification
REQ-031 N=4, sched_en=1, only VOQ (2,1) nonempty at cycle 0: rd_en=0100 with rd_sel[2]=1 at edge 1; wr_en=0010 with mux_sel[1]=2 at edge 2; g_ptr[1]=3 and a_ptr[2]=2.
REQ-032 N=4, inputs 0..3 all nonempty for output 0 and held: grants rotate 0,2,1,3? No -- with the REQ-013 mask, wr_en[0] SHALL occur every cycle and the input sequence SHALL be 0,1,2,3,0 with no input served twice before all four are served.
REQ-033 N=4, full permutation with VOQ (i,(i+1) mod 4) nonempty for all i: rd_en=1111 at edge 1 and wr_en=1111 at edge 2; mux_sel = {2,1,0,3} for fields 3..0.
REQ-034 out_full[3]=1 with inputs requesting output 3: no rd_en toward output 3 while full; after out_full falls, a read issues at the next edge.
REQ-035 Match made at cycle t with rst_n pulled low at t+1: all outputs SHALL be 0 immediately; no wr_en at t+2; pointers SHALL read 0 after reset.
REQ-036 sched_en dropped at the same edge that rd_en is issued: the paired wr_en SHALL still occur one cycle later, and rd_en SHALL be 0 afterwards.
